// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keyboard event FIFO between scanner and SPI reply path; optional KEY_FIFO_OVF_MARKER_EN puts an 8'hFF drop marker in the stream
module key_event_fifo #(
    parameter int                WIDTH      = 8,
    parameter int                DEPTH_LOG2 = 4,
    parameter logic [WIDTH-1:0]  EMPTY_CODE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    output logic [WIDTH-1:0]      rdData,
    input  logic                  clr,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = (DEPTH_LOG2)'(1);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count_q;
    logic [DEPTH_LOG2:0]    count_next;
    logic                   ovf_q;
    logic [WIDTH-1:0]       rd_data_q;

    logic                   is_empty;
    logic                   is_full;
    logic                   do_write;
    logic                   do_read;
    logic                   drop;
    logic                   empty_read;
    logic [WIDTH-1:0]       empty_fill;

    // Strobe qualification: a full FIFO still accepts a write when a read frees a slot on the same edge
    always_comb begin
        is_empty   = (count_q == '0);
        is_full    = (count_q == FULL_COUNT);
        do_read    = rdEn && !is_empty;
        do_write   = wrEn && (!is_full || rdEn);
        drop       = wrEn && is_full && !rdEn;
        empty_read = rdEn && is_empty;
        count_next = count_q;
        case ({do_write, do_read})
            2'b10:   count_next = count_q + ONE_COUNT;
            2'b01:   count_next = count_q - ONE_COUNT;
            default: count_next = count_q;
        endcase
    end

`ifdef KEY_FIFO_OVF_MARKER_EN
    logic mark_pend;

    // Remember a drop until an empty read can report it in the data stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mark_pend <= 1'b0;
        end else if (clr) begin
            mark_pend <= 1'b0;
        end else if (drop) begin
            mark_pend <= 1'b1;
        end else if (empty_read) begin
            mark_pend <= 1'b0;
        end
    end

    assign empty_fill = mark_pend ? {WIDTH{1'b1}} : EMPTY_CODE;
`else
    assign empty_fill = EMPTY_CODE;
`endif

    // Storage array; no reset since contents behind the pointers are never observed
    always_ff @(posedge clk) begin
        if (do_write && !clr && rst) begin
            mem[wr_ptr] <= wrData;
        end
    end

    // Pointers, occupancy, sticky overflow and registered read data; clear outranks both strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= EMPTY_CODE;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= EMPTY_CODE;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (do_read) begin
                rd_ptr    <= rd_ptr + ONE_PTR;
                rd_data_q <= mem[rd_ptr];
            end else if (empty_read) begin
                rd_data_q <= empty_fill;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_next;
        end
    end

    assign rdData = rd_data_q;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign empty  = is_empty;
    assign full   = is_full;

endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - directed bench for key_event_fifo
module tb_key_event_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrEn = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       rdEn = 1'b0;
    logic [7:0] rdData;
    logic       clr = 1'b0;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;

    int total = 0;
    int bad = 0;

`ifdef KEY_FIFO_OVF_MARKER_EN
    localparam logic [7:0] MARK_EXP = 8'hFF;
`else
    localparam logic [7:0] MARK_EXP = 8'h00;
`endif

    key_event_fifo dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
        .rdData(rdData), .clr(clr), .empty(empty), .full(full),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        wrEn = w; wrData = d; rdEn = r; clr = c;
        @(posedge clk);
        #1;
        wrEn = 1'b0; rdEn = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (rdData !== 8'h00) begin bad++; $display("FAIL reset_rddata got=%h exp=00", rdData); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
        total++; if (count !== 5'd0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_count got=%0d/%b exp=0/0", count, ovf); end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h00 || empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL empty_read got=%h/%b/%0d exp=00/1/0", rdData, empty, count); end
    endtask

    task automatic test_basic;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33;
        for (int i = 0; i < 3; i++) step(1'b1, exp_q[i], 1'b0, 1'b0);
        total++; if (count !== 5'd3 || empty !== 1'b0) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (rdData !== exp_q[i]) begin bad++; $display("FAIL basic_read%0d got=%h exp=%h", i, rdData, exp_q[i]); end
        end
        total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL basic_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_overflow;
        int errs = 0;
        for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        total++; if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_state got=%b/%0d/%b exp=1/16/1", full, count, ovf); end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (rdData !== 8'(i)) begin errs++; $display("FAIL ovf_read%0d got=%h exp=%h", i, rdData, 8'(i)); end
        end
        total++; if (errs != 0) bad++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== MARK_EXP) begin bad++; $display("FAIL ovf_marker got=%h exp=%h", rdData, MARK_EXP); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h00 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_after_marker got=%h/%b exp=00/1", rdData, ovf); end
    endtask

    task automatic test_full_rw;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        total++; if (rdData !== 8'h20) begin bad++; $display("FAIL fullrw_read got=%h exp=20", rdData); end
        total++; if (count !== 5'd16 || full !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL fullrw_state got=%0d/%b/%b exp=16/1/0", count, full, ovf); end
        for (int i = 1; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h2F) begin bad++; $display("FAIL fullrw_15th got=%h exp=2f", rdData); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'hAA || empty !== 1'b1) begin bad++; $display("FAIL fullrw_16th got=%h/%b exp=aa/1", rdData, empty); end
    endtask

    task automatic test_clear;
        for (int i = 0; i < 17; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (count !== 5'd5 || ovf !== 1'b1) begin bad++; $display("FAIL clr_pre got=%0d/%b exp=5/1", count, ovf); end
        step(1'b1, 8'h55, 1'b0, 1'b1);
        total++; if (count !== 5'd0 || ovf !== 1'b0 || empty !== 1'b1 || rdData !== 8'h00) begin bad++; $display("FAIL clr_state got=%0d/%b/%b/%h exp=0/0/1/00", count, ovf, empty, rdData); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h00) begin bad++; $display("FAIL clr_read got=%h exp=00", rdData); end
    endtask

    task automatic test_empty_rw;
        step(1'b1, 8'h77, 1'b1, 1'b0);
        total++; if (rdData !== 8'h00 || count !== 5'd1) begin bad++; $display("FAIL emptyrw got=%h/%0d exp=00/1", rdData, count); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h77 || empty !== 1'b1) begin bad++; $display("FAIL emptyrw_read got=%h/%b exp=77/1", rdData, empty); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (count !== 5'd7 || rdData !== 8'h60) begin bad++; $display("FAIL arst_pre got=%0d/%h exp=7/60", count, rdData); end
        @(negedge clk);
        rdEn = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++; if (count !== 5'd0 || rdData !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL arst_now got=%0d/%h/%b/%b/%b exp=0/00/1/0/0", count, rdData, empty, full, ovf); end
        @(posedge clk);
        #1;
        total++; if (count !== 5'd0 || rdData !== 8'h00) begin bad++; $display("FAIL arst_held got=%0d/%h exp=0/00", count, rdData); end
        @(negedge clk);
        rdEn = 1'b0;
        rst = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL arst_first got=%0d exp=1", count); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rdData !== 8'h99) begin bad++; $display("FAIL arst_read got=%h exp=99", rdData); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_clear();
        test_empty_rw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
